// File: rtl/lc2k_mem_pkg.sv
// Shared types and constants for the LC2K memory arbiter.
package lc2k_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/lc2k_rr_arb2.sv
// Two-request round-robin picker: bit 0 is IF, bit 1 is LS.
// The last-grant history lives in the parent so this block stays combinational.
module lc2k_rr_arb2
  import lc2k_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // A lone request wins outright; on a tie the port not granted last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWNER_IF;
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (req[1]) begin
      gnt_id = OWNER_LS;
    end
  end

endmodule

// File: rtl/lc2k_mem_arbiter.sv
// Shares one single-port LC2K memory between instruction fetch (IF) and
// load/store (LS). One transaction at a time: IDLE -> ISSUE -> [WAIT] -> RESP.
//
// Handshake: a port raises req and holds req/addr/we/wdata stable until its
// done pulses for one cycle; done marks the write committed or rdata valid.
// Requests are only sampled in IDLE, so a req seen while busy simply waits,
// and a req dropped after being sampled does not cancel the transaction.
module lc2k_mem_arbiter
  import lc2k_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy,
  output logic              arb_owner
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             cmd_we;
  logic             gnt_valid;
  logic             gnt_id;

  lc2k_rr_arb2 u_rr (
    .req       ({ls_req, if_req}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Transaction sequencer; every output is a register written here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= OWNER_LS;
      cmd_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      arb_busy  <= 1'b0;
      arb_owner <= OWNER_IF;
    end else begin
      // Strobes and done pulses are single-cycle unless re-asserted below.
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            arb_owner <= gnt_id;
            last_gnt  <= gnt_id;
            arb_busy  <= 1'b1;
            mem_en    <= 1'b1;
            state     <= ISSUE;
            if (gnt_id == OWNER_LS) begin
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_we    <= ls_we;
              cmd_we    <= ls_we;
            end else begin
              mem_addr <= if_addr;
              cmd_we   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            // Writes commit in the mem_en cycle; only LS can write.
            ls_done <= 1'b1;
            state   <= RESP;
          end else begin
            cnt   <= CNT_W'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (arb_owner == OWNER_LS) begin
              ls_rdata <= mem_rdata;
              ls_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc2k_mem_arbiter.sv
// Directed bench for lc2k_mem_arbiter: instance a uses MEM_LAT=1, instance b
// uses MEM_LAT=3. Each instance has its own memory model that returns a
// poison word whenever no read was issued, so mistimed captures are visible.
module tb_lc2k_mem_arbiter;

  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- instance a (MEM_LAT=1) ----------------
  logic        a_if_req, a_if_done, a_ls_req, a_ls_we, a_ls_done;
  logic [5:0]  a_if_addr, a_ls_addr, a_mem_addr;
  logic [31:0] a_if_rdata, a_ls_wdata, a_ls_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_en, a_mem_we, a_arb_busy, a_arb_owner;

  lc2k_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_done(a_if_done), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_done(a_ls_done), .ls_rdata(a_ls_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .arb_busy(a_arb_busy), .arb_owner(a_arb_owner)
  );

  // ---------------- instance b (MEM_LAT=3) ----------------
  logic        b_if_req, b_if_done, b_ls_req, b_ls_we, b_ls_done;
  logic [5:0]  b_if_addr, b_ls_addr, b_mem_addr;
  logic [31:0] b_if_rdata, b_ls_wdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_en, b_mem_we, b_arb_busy, b_arb_owner;

  lc2k_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_done(b_ls_done), .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .arb_busy(b_arb_busy), .arb_owner(b_arb_owner)
  );

  // ---------------- memory models ----------------
  // Contents: a[i] = 0x100+i except a[9] = 1; b[i] = 0x200+i.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  assign a_mem_rdata = pipe_a;
  assign b_mem_rdata = pipe_b[2];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 32'h100 + 32'(i);
      mem_a[9] <= 32'h1;
      pipe_a   <= POISON;
    end else begin
      if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
      pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : POISON;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 32'h200 + 32'(i);
      for (int i = 0; i < 3; i++) pipe_b[i] <= POISON;
    end else begin
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
      pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : POISON;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_en"},    64'(a_mem_en),    64'h0);
    check({tag, "_mem_we"},    64'(a_mem_we),    64'h0);
    check({tag, "_if_done"},   64'(a_if_done),   64'h0);
    check({tag, "_ls_done"},   64'(a_ls_done),   64'h0);
    check({tag, "_busy"},      64'(a_arb_busy),  64'h0);
    check({tag, "_mem_addr"},  64'(a_mem_addr),  64'h0);
    check({tag, "_mem_wdata"}, 64'(a_mem_wdata), 64'h0);
    check({tag, "_if_rdata"},  64'(a_if_rdata),  64'h0);
    check({tag, "_ls_rdata"},  64'(a_ls_rdata),  64'h0);
    check({tag, "_owner"},     64'(a_arb_owner), 64'h0);
  endtask

  // IF read on instance a with the request sampled in cycle 0.
  task automatic if_read(input logic [5:0] addr, input logic [31:0] exp, input string tag);
    a_if_req  = 1'b1;
    a_if_addr = addr;
    tick();  // cycle 1
    check({tag, "_c1_mem_en"}, 64'(a_mem_en),    64'h1);
    check({tag, "_c1_addr"},   64'(a_mem_addr),  64'(addr));
    check({tag, "_c1_we"},     64'(a_mem_we),    64'h0);
    check({tag, "_c1_owner"},  64'(a_arb_owner), 64'h0);
    check({tag, "_c1_busy"},   64'(a_arb_busy),  64'h1);
    tick();  // cycle 2
    check({tag, "_c2_mem_en"}, 64'(a_mem_en),  64'h0);
    check({tag, "_c2_done"},   64'(a_if_done), 64'h0);
    tick();  // cycle 3
    check({tag, "_c3_done"},   64'(a_if_done),  64'h1);
    check({tag, "_c3_rdata"},  64'(a_if_rdata), 64'(exp));
    check({tag, "_c3_ls_done"},64'(a_ls_done),  64'h0);
    a_if_req = 1'b0;
    tick();  // cycle 4
    check({tag, "_c4_done"}, 64'(a_if_done),  64'h0);
    check({tag, "_c4_busy"}, 64'(a_arb_busy), 64'h0);
  endtask

  // LS write or read on instance a with the request sampled in cycle 0.
  task automatic ls_op(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input string tag);
    a_ls_req   = 1'b1;
    a_ls_we    = we;
    a_ls_addr  = addr;
    a_ls_wdata = wdata;
    tick();  // cycle 1
    check({tag, "_c1_mem_en"}, 64'(a_mem_en),    64'h1);
    check({tag, "_c1_we"},     64'(a_mem_we),    64'(we));
    check({tag, "_c1_addr"},   64'(a_mem_addr),  64'(addr));
    check({tag, "_c1_owner"},  64'(a_arb_owner), 64'h1);
    if (we) begin
      check({tag, "_c1_wdata"}, 64'(a_mem_wdata), 64'(wdata));
      tick();  // cycle 2
      check({tag, "_c2_done"}, 64'(a_ls_done), 64'h1);
      a_ls_req = 1'b0;
      tick();  // cycle 3
      check({tag, "_c3_done"}, 64'(a_ls_done),  64'h0);
      check({tag, "_c3_busy"}, 64'(a_arb_busy), 64'h0);
    end else begin
      tick();  // cycle 2
      check({tag, "_c2_done"}, 64'(a_ls_done), 64'h0);
      tick();  // cycle 3
      check({tag, "_c3_done"},    64'(a_ls_done),  64'h1);
      check({tag, "_c3_rdata"},   64'(a_ls_rdata), 64'(exp));
      check({tag, "_c3_if_done"}, 64'(a_if_done),  64'h0);
      a_ls_req = 1'b0;
      tick();  // cycle 4
      check({tag, "_c4_busy"}, 64'(a_arb_busy), 64'h0);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a_first, a_second, b_first, b_second, b_done, n_done;
    logic exp_owner;

    reset_n = 1'b0;
    a_if_req = 1'b0; a_if_addr = '0; a_ls_req = 1'b0; a_ls_we = 1'b0;
    a_ls_addr = '0; a_ls_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_ls_req = 1'b0; b_ls_we = 1'b0;
    b_ls_addr = '0; b_ls_wdata = '0;
    #1;
    check_reset_vals("rst0");
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();

    // IF read of word 9 (holds 1).
    if_read(6'd9, 32'h1, "if9");

    // LS write 8 to word 11, then read it back; if_rdata must hold.
    ls_op(1'b1, 6'd11, 32'h8, 32'h0, "lsw11");
    ls_op(1'b0, 6'd11, 32'h0, 32'h8, "lsr11");
    check("hold_if_rdata", 64'(a_if_rdata), 64'h1);

    // Tie after reset: both held high for three transactions -> IF, LS, IF.
    pulse_reset();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    a_if_req = 1'b1; a_if_addr = 6'd9;
    a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_addr = 6'd5;
    n_done = 0;
    for (int c = 1; c <= 30 && n_done < 3; c++) begin
      tick();
      if (a_if_done || a_ls_done) begin
        exp_owner = exp_q.pop_front();
        check("tie_one_done", 64'(a_if_done) + 64'(a_ls_done), 64'h1);
        check("tie_order", 64'(a_ls_done), 64'(exp_owner));
        check("tie_owner", 64'(a_arb_owner), 64'(exp_owner));
        if (exp_owner) check("tie_ls_rdata", 64'(a_ls_rdata), 64'h105);
        else           check("tie_if_rdata", 64'(a_if_rdata), 64'h1);
        n_done++;
      end
    end
    a_if_req = 1'b0;
    a_ls_req = 1'b0;
    check("tie_done_count", 64'(n_done), 64'h3);
    tick();
    check("tie_idle", 64'(a_arb_busy), 64'h0);

    // Back-to-back IF reads with req held: spacing on both latencies.
    a_first = -1; a_second = -1; b_first = -1; b_second = -1; b_done = -1;
    a_if_req = 1'b1; a_if_addr = 6'd9;
    b_if_req = 1'b1; b_if_addr = 6'd9;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (a_mem_en) begin
        if (a_first < 0) a_first = c;
        else if (a_second < 0) a_second = c;
      end
      if (b_mem_en) begin
        if (b_first < 0) b_first = c;
        else if (b_second < 0) b_second = c;
      end
      if (b_if_done && b_done < 0) begin
        b_done = c;
        check("lat3_rdata", 64'(b_if_rdata), 64'h209);
      end
    end
    a_if_req = 1'b0;
    b_if_req = 1'b0;
    check("b2b_a_first",   64'(a_first),            64'h1);
    check("b2b_a_spacing", 64'(a_second - a_first), 64'h4);
    check("b2b_b_spacing", 64'(b_second - b_first), 64'h6);
    check("b2b_b_done",    64'(b_done - b_first),   64'h4);
    for (int c = 0; c < 20 && (a_arb_busy || b_arb_busy); c++) tick();
    check("b2b_idle", 64'(a_arb_busy | b_arb_busy), 64'h0);

    // LS read whose request drops right after being sampled.
    a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_addr = 6'd5;
    tick();  // cycle 1
    a_ls_req = 1'b0;
    check("drop_c1_mem_en", 64'(a_mem_en), 64'h1);
    tick();  // cycle 2
    check("drop_c2_done", 64'(a_ls_done), 64'h0);
    tick();  // cycle 3
    check("drop_c3_done",  64'(a_ls_done),  64'h1);
    check("drop_c3_rdata", 64'(a_ls_rdata), 64'h105);
    tick();

    // Reset during WAIT: immediate reset values, no done, then recovery.
    a_if_req = 1'b1; a_if_addr = 6'd9;
    tick();  // cycle 1
    tick();  // cycle 2 (WAIT)
    check("rstw_busy_before", 64'(a_arb_busy), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rstw");
    a_if_req = 1'b0;
    tick();
    check("rstw_no_done1", 64'(a_if_done), 64'h0);
    tick();
    check("rstw_no_done2", 64'(a_if_done), 64'h0);
    reset_n = 1'b1;
    tick();
    check("rstw_idle", 64'(a_arb_busy), 64'h0);
    if_read(6'd9, 32'h1, "rec9");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
